// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block: counter width and channel state encoding.
// The clock divider sizes its divisor with the same CNT_W.
package pwm_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_channel_if.sv
// Control/status bundle of one PWM channel. The channel takes the slave side,
// whatever programs it (register block or testbench) takes the master side.
interface pwm_channel_if;
  import pwm_pkg::*;

  logic             en_i;
  logic             tick_src_i;
  logic [CNT_W-1:0] period_i;
  logic [CNT_W-1:0] duty_i;
  logic             polarity_i;
  logic             oneshot_i;
  logic             load_i;
  logic             pwm_o;
  logic             oe_o;
  logic             period_end_o;
  logic             busy_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    output en_i, tick_src_i, period_i, duty_i, polarity_i, oneshot_i, load_i,
    input  pwm_o, oe_o, period_end_o, busy_o, cnt_o
  );

  modport slave (
    input  en_i, tick_src_i, period_i, duty_i, polarity_i, oneshot_i, load_i,
    output pwm_o, oe_o, period_end_o, busy_o, cnt_o
  );

endinterface

// File: rtl/pwm_tick_detect.sv
// Turns a divided clock (synchronous to clk_i) into a one-cycle tick on each
// of its rising edges. Shared by every consumer of the divider outputs.
module pwm_tick_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic tick_o
);

  logic src_d, src_q;

  assign src_d = src_i;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= 1'b0;
    end else begin
      src_q <= src_d;
    end
  end

  assign tick_o = src_i & ~src_q;

endmodule

// File: rtl/pwm_channel.sv
// One PWM waveform generator: counts divider ticks over a shadowed period and
// drives a duty-controlled, polarity-adjusted output plus a period-end pulse.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  pwm_channel_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_s_q, per_s_d;
  logic [CNT_W-1:0] duty_s_q, duty_s_d;
  logic             load_pend_q, load_pend_d;
  logic             pwm_q, pwm_d;
  logic             oe_q, oe_d;
  logic             period_end_q, period_end_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             active;

  pwm_tick_detect u_tick_detect (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .src_i  (bus.tick_src_i),
    .tick_o (tick)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    per_s_d      = per_s_q;
    duty_s_d     = duty_s_q;
    load_pend_d  = load_pend_q;
    period_end_d = 1'b0;

    if (!bus.en_i) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      load_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_RUN;
          per_s_d     = bus.period_i;
          duty_s_d    = bus.duty_i;
          load_pend_d = 1'b0;
          cnt_d       = '0;
        end
        ST_RUN: begin
          if (bus.load_i) begin
            load_pend_d = 1'b1;
          end
          // A zero period parks the counter at 0: no wrap, no period-end pulse.
          if (tick && (per_s_q != '0)) begin
            if (cnt_q == per_s_q - CNT_W'(1)) begin
              cnt_d        = '0;
              period_end_d = 1'b1;
              if (load_pend_q || bus.load_i) begin
                per_s_d     = bus.period_i;
                duty_s_d    = bus.duty_i;
                load_pend_d = 1'b0;
              end
              if (bus.oneshot_i) begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs derive from next-state values so the registered pwm_o lines up
    // with the registered cnt_o in the same cycle.
    busy_d = (state_d == ST_RUN);
    oe_d   = busy_d;
    active = busy_d && (cnt_d < duty_s_d) && (per_s_d != '0);
    pwm_d  = active ^ bus.polarity_i;
  end

  // NOTE: shadows are plain flops, not a memory, so they take the async reset
  // together with the rest of the channel state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      per_s_q      <= '0;
      duty_s_q     <= '0;
      load_pend_q  <= 1'b0;
      pwm_q        <= 1'b0;
      oe_q         <= 1'b0;
      period_end_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_s_q      <= per_s_d;
      duty_s_q     <= duty_s_d;
      load_pend_q  <= load_pend_d;
      pwm_q        <= pwm_d;
      oe_q         <= oe_d;
      period_end_q <= period_end_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.pwm_o        = pwm_q;
  assign bus.oe_o         = oe_q;
  assign bus.period_end_o = period_end_q;
  assign bus.busy_o       = busy_q;
  assign bus.cnt_o        = cnt_q;

endmodule

// File: tb/tb_pwm_channel.sv
// Self-checking bench for pwm_channel: directed scenarios plus randomized
// stimulus, all compared cycle by cycle against a behavioural channel model.
module tb_pwm_channel;

  logic clk;
  logic rst_n;

  pwm_channel_if pif ();

  pwm_channel dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 finished one-shot.
  int m_mode, m_cnt, m_sp, m_sd;
  bit m_pend, m_prev;
  bit e_pwm, e_oe, e_pe, e_busy;
  int e_cnt;

  // Divided-clock generator and observation counters.
  int div = 1;
  int div_cnt = 0;
  int pe_seen, hi_seen, cnt_max;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_sp = 0; m_sd = 0; m_pend = 0; m_prev = 0;
    e_pwm = 0; e_oe = 0; e_pe = 0; e_busy = 0; e_cnt = 0;
  endtask

  task automatic model_edge();
    bit tick;
    tick   = pif.tick_src_i && !m_prev;
    m_prev = pif.tick_src_i;
    e_pe   = 0;
    if (!pif.en_i) begin
      m_mode = 0; m_cnt = 0; m_pend = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_cnt = 0; m_pend = 0;
      m_sp = int'(pif.period_i); m_sd = int'(pif.duty_i);
    end else if (m_mode == 1) begin
      m_pend = m_pend || pif.load_i;
      if (tick && m_sp > 0) begin
        m_cnt = (m_cnt + 1) % m_sp;
        if (m_cnt == 0) begin
          e_pe = 1;
          if (m_pend) begin
            m_sp = int'(pif.period_i); m_sd = int'(pif.duty_i); m_pend = 0;
          end
          if (pif.oneshot_i) m_mode = 2;
        end
      end
    end
    e_busy = (m_mode == 1);
    e_oe   = e_busy;
    e_cnt  = m_cnt;
    e_pwm  = pif.polarity_i ^ (e_busy && m_sp != 0 && m_cnt < m_sd);
  endtask

  task automatic compare_outputs();
    check("pwm_o", pif.pwm_o, e_pwm);
    check("oe_o", pif.oe_o, e_oe);
    check("period_end_o", pif.period_end_o, e_pe);
    check("busy_o", pif.busy_o, e_busy);
    check("cnt_o", pif.cnt_o, e_cnt);
  endtask

  // One clk cycle: model follows the edge, outputs checked 1 unit later,
  // then the divided clock advances for the next edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_outputs();
    pe_seen += int'(pif.period_end_o);
    hi_seen += int'(pif.pwm_o);
    if (int'(pif.cnt_o) > cnt_max) cnt_max = int'(pif.cnt_o);
    div_cnt++;
    if (div_cnt >= div) begin
      div_cnt = 0;
      pif.tick_src_i = ~pif.tick_src_i;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    pe_seen = 0; hi_seen = 0; cnt_max = 0;
  endtask

  task automatic wait_cnt(input string tag, input int target, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      found = (m_mode == 1 && m_cnt == target);
    end
    check(tag, found, 1);
  endtask

  // Stops just before the edge on which the model will wrap.
  task automatic wait_wrap_next(input string tag, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      found = (m_mode == 1 && m_sp > 0 && m_cnt == m_sp - 1 &&
               pif.tick_src_i && !m_prev);
      if (!found) step();
    end
    check(tag, found, 1);
  endtask

  task automatic pulse_load(input int per, input int duty);
    pif.period_i = per[15:0];
    pif.duty_i   = duty[15:0];
    pif.load_i   = 1'b1;
    step();
    pif.load_i   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pif.en_i = 1'b0; pif.tick_src_i = 1'b0; pif.period_i = '0; pif.duty_i = '0;
    pif.polarity_i = 1'b0; pif.oneshot_i = 1'b0; pif.load_i = 1'b0;
    model_reset();
    clear_counts();
    #2;
    compare_outputs();
    run(2);
    #2 rst_n = 1'b1;

    // Period 4, duty 1, tick every 2 clk: high 2 of 8 clk, one pulse per 8 clk.
    div = 1;
    pif.period_i = 16'd4; pif.duty_i = 16'd1; pif.en_i = 1'b1;
    run(16);
    clear_counts();
    run(32);
    check("t1_period_end_count", pe_seen, 4);
    check("t1_high_count", hi_seen, 8);
    check("t1_cnt_max", cnt_max, 3);

    // 100% duty, then duty 0 loaded mid-period: stays 100% until the wrap.
    pulse_load(4, 4);
    run(16);
    wait_cnt("t2_reach_cnt1", 1, 40);
    pulse_load(4, 0);
    check("t2_hold_full_duty", pif.pwm_o, 1);
    run(16);
    clear_counts();
    run(16);
    check("t2_zero_duty_high", hi_seen, 0);
    pif.duty_i = 16'd2;
    wait_wrap_next("t2_find_wrap", 40);
    pulse_load(4, 2);
    check("t2_wrap_load_pwm", pif.pwm_o, 1);
    check("t2_wrap_load_cnt", pif.cnt_o, 0);
    check("t2_wrap_load_pe", pif.period_end_o, 1);

    // Active-low, period 5, duty 2: low 4 clk of every 10.
    pif.polarity_i = 1'b1;
    pulse_load(5, 2);
    run(30);
    clear_counts();
    run(20);
    check("t3_high_count", hi_seen, 12);
    pif.en_i = 1'b0;
    run(2);
    check("t3_idle_pwm", pif.pwm_o, 1);
    check("t3_idle_oe", pif.oe_o, 0);

    // One-shot: exactly one period, then DONE until en_i drops.
    pif.polarity_i = 1'b0; pif.oneshot_i = 1'b1;
    pif.period_i = 16'd3; pif.duty_i = 16'd1; pif.en_i = 1'b1;
    clear_counts();
    run(40);
    check("t4_single_period_end", pe_seen, 1);
    check("t4_done_busy", pif.busy_o, 0);
    check("t4_done_pwm", pif.pwm_o, 0);
    pif.en_i = 1'b0;
    step();
    pif.en_i = 1'b1;
    step();
    check("t4_restart_busy", pif.busy_o, 1);
    check("t4_restart_cnt", pif.cnt_o, 0);
    pif.oneshot_i = 1'b0;

    // Zero period: no pulses over 100+ ticks, output inactive, counter at 0.
    pif.en_i = 1'b0;
    step();
    pif.period_i = 16'd0; pif.duty_i = 16'd3; pif.en_i = 1'b1;
    clear_counts();
    run(220);
    check("t5_no_period_end", pe_seen, 0);
    check("t5_no_high", hi_seen, 0);
    check("t5_cnt_max", cnt_max, 0);

    // Asynchronous reset at cnt 2 of a period-4 run.
    pif.en_i = 1'b0;
    step();
    pif.period_i = 16'd4; pif.duty_i = 16'd3; pif.en_i = 1'b1;
    wait_cnt("t6_reach_cnt2", 2, 40);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_pwm", pif.pwm_o, 0);
    check("t6_rst_oe", pif.oe_o, 0);
    check("t6_rst_pe", pif.period_end_o, 0);
    check("t6_rst_busy", pif.busy_o, 0);
    check("t6_rst_cnt", pif.cnt_o, 0);
    pif.tick_src_i = 1'b0; div_cnt = 0;
    run(3);
    rst_n = 1'b1;
    step();
    check("t6_restart_busy", pif.busy_o, 1);
    check("t6_restart_cnt", pif.cnt_o, 0);
    run(20);

    // Randomized traffic: unloaded period/duty churn, loads, enables, one-shot.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) div = int'($urandom_range(1, 3));
      pif.period_i   = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 9));
      pif.duty_i     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 10));
      pif.load_i     = ($urandom_range(0, 7) == 0);
      pif.en_i       = ($urandom_range(0, 63) != 0);
      pif.oneshot_i  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) pif.polarity_i = ~pif.polarity_i;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
